// File: rtl/key_event_arbiter_pkg.sv
// Shared types and sizing helpers for the key event arbiter and its picker.
package key_event_arbiter_pkg;

    // Arbiter control states; exported on the debug port so checkers can follow the FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Width of a key index; a single key still needs one bit on the port.
    function automatic int key_width(input int keys_cnt);
        return (keys_cnt > 1) ? $clog2(keys_cnt) : 1;
    endfunction

    // Quiet gap after each accepted event, in clock cycles (integer division).
    function automatic int gap_cycles(input int gap_ns, input int clk_freq_mhz);
        return (gap_ns * clk_freq_mhz) / 1000;
    endfunction

    // Gap counter width: enough to hold GAP_CYCLES, never narrower than one bit.
    function automatic int gap_cnt_width(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/key_event_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr wins,
// otherwise the search wraps and the lowest set request wins.
module rr_pick #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic             hi_any;
    logic [IDX_W-1:0] hi_idx;
    logic             lo_any;
    logic [IDX_W-1:0] lo_idx;

    // Scan downwards so the last hit in each class is the lowest index of that class.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_any = 1'b1;
                lo_idx = IDX_W'(k);
                if (k >= int'(ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(k);
                end
            end
        end
        any = lo_any;
        idx = hi_any ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/key_event_arbiter.sv
// Serialises one-cycle key press strobes into a single registered event stream.
// Presses are held in a pending bitmap, served round-robin, and each accepted
// event is followed by a fixed quiet gap before the next one is offered.
//
// Handshake: an event transfers on a rising clk_i edge where evt_valid_o and
// evt_ready_i are both high. Once raised, evt_valid_o and evt_key_o stay
// stable until that transfer; the offer is never withdrawn. evt_ready_i is
// ignored whenever evt_valid_o is low, so it may be held high permanently.
module key_event_arbiter
    import key_event_arbiter_pkg::*;
#(
    parameter  int KEYS_CNT     = 4,
    parameter  int CLK_FREQ_MHZ = 150,
    parameter  int GAP_NS       = 100,
    localparam int KEY_W        = key_width(KEYS_CNT)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [KEYS_CNT-1:0] key_stb_i,
    output logic                evt_valid_o,
    output logic [KEY_W-1:0]    evt_key_o,
    input  logic                evt_ready_i,
    output logic [KEYS_CNT-1:0] pending_o,
    output logic [KEYS_CNT-1:0] overrun_o,
    input  logic [KEYS_CNT-1:0] ovr_clr_i,
    output state_e              dbg_state_o
);

    localparam int                GAP_CYCLES = gap_cycles(GAP_NS, CLK_FREQ_MHZ);
    localparam int                CNT_W      = gap_cnt_width(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [KEY_W-1:0]  LAST_KEY   = KEY_W'(KEYS_CNT - 1);

    state_e                state_q;
    state_e                state_d;
    logic                  evt_valid_q;
    logic                  evt_valid_d;
    logic [KEY_W-1:0]      evt_key_q;
    logic [KEY_W-1:0]      evt_key_d;
    logic [KEY_W-1:0]      rr_ptr_q;
    logic [KEY_W-1:0]      rr_ptr_d;
    logic [CNT_W-1:0]      gap_cnt_q;
    logic [CNT_W-1:0]      gap_cnt_d;
    logic [KEYS_CNT-1:0]   pending_q;
    logic [KEYS_CNT-1:0]   pending_d;
    logic [KEYS_CNT-1:0]   overrun_q;
    logic [KEYS_CNT-1:0]   overrun_d;

    logic                  accept;
    logic [KEYS_CNT-1:0]   acc_mask;
    logic [KEY_W-1:0]      win_idx;
    logic                  win_any;

    // The valid flag is only ever high in OFFER, so this is the OFFER-state transfer.
    assign accept = evt_valid_q & evt_ready_i;

    rr_pick #(
        .WIDTH (KEYS_CNT),
        .IDX_W (KEY_W)
    ) u_rr_pick (
        .req (pending_q),
        .ptr (rr_ptr_q),
        .idx (win_idx),
        .any (win_any)
    );

    // Pending and overrun bookkeeping: a fresh strobe on the key being accepted
    // re-arms it as a new event; a strobe on any other still-pending key is lost.
    always_comb begin
        acc_mask  = '0;
        if (accept) begin
            acc_mask = KEYS_CNT'(1) << evt_key_q;
        end
        pending_d = (pending_q & ~acc_mask) | key_stb_i;
        overrun_d = (overrun_q & ~ovr_clr_i) | (key_stb_i & pending_q & ~acc_mask);
    end

    // Next-state and registered-output logic for the offer / gap sequence.
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        rr_ptr_d    = rr_ptr_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    evt_key_d   = win_idx;
                    evt_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (accept) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = (evt_key_q == LAST_KEY) ? '0 : evt_key_q + 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any offer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: offered event, pointer, gap counter and key bitmaps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            rr_ptr_q    <= '0;
            gap_cnt_q   <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            rr_ptr_q    <= rr_ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_key_o   = evt_key_q;
    assign pending_o   = pending_q;
    assign overrun_o   = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus random traffic, all
// tracked by a timestamp-based reference model of the arbiter's rules.
module tb_key_event_arbiter;
    import key_event_arbiter_pkg::*;

    localparam int N       = 4;
    localparam int CLK_MHZ = 150;
    localparam int GAP     = 100;
    localparam int G       = GAP * CLK_MHZ / 1000;
    localparam int KW      = 2;
    localparam int VW      = 1 + KW + 2 * N;

    // ---------------- clock / reset ----------------
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]  key_stb_i   = '0;
    logic [N-1:0]  ovr_clr_i   = '0;
    logic          evt_ready_i = 1'b0;
    logic          evt_valid_o;
    logic [KW-1:0] evt_key_o;
    logic [N-1:0]  pending_o;
    logic [N-1:0]  overrun_o;
    state_e        dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;

    key_event_arbiter #(
        .KEYS_CNT     (N),
        .CLK_FREQ_MHZ (CLK_MHZ),
        .GAP_NS       (GAP)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_stb_i   (key_stb_i),
        .evt_valid_o (evt_valid_o),
        .evt_key_o   (evt_key_o),
        .evt_ready_i (evt_ready_i),
        .pending_o   (pending_o),
        .overrun_o   (overrun_o),
        .ovr_clr_i   (ovr_clr_i),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- reference model ----------------
    // Events are offered whenever nothing is on offer, the quiet window since
    // the last accept has elapsed, and something was pending before the edge.
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_ovr;
    int            m_ptr;
    bit            m_valid;
    int            m_key;
    int            m_free_at;
    int            tb_cyc = 0;
    logic [KW-1:0] acc_key_q[$];
    int            acc_cyc_q[$];
    logic [KW-1:0] exp_q[$];

    always @(posedge clk_i or negedge rst_ni) begin : ref_model
        logic [N-1:0] old_pend;
        bit           acc;
        bit           taken;
        int           win;
        if (!rst_ni) begin
            m_pend    = '0;
            m_ovr     = '0;
            m_ptr     = 0;
            m_valid   = 1'b0;
            m_key     = 0;
            m_free_at = 0;
        end else begin
            tb_cyc++;
            if (evt_valid_o && evt_ready_i) begin
                acc_key_q.push_back(evt_key_o);
                acc_cyc_q.push_back(tb_cyc);
            end
            old_pend = m_pend;
            acc      = m_valid && evt_ready_i;
            for (int k = 0; k < N; k++) begin
                taken = acc && (m_key == k);
                if (key_stb_i[k] && old_pend[k] && !taken) m_ovr[k] = 1'b1;
                else if (ovr_clr_i[k])                     m_ovr[k] = 1'b0;
                if (taken)        m_pend[k] = 1'b0;
                if (key_stb_i[k]) m_pend[k] = 1'b1;
            end
            if (acc) begin
                m_valid   = 1'b0;
                m_ptr     = (m_key + 1) % N;
                m_free_at = tb_cyc + G + 1;
            end else if (!m_valid && tb_cyc >= m_free_at) begin
                win = -1;
                for (int i = 0; i < N; i++) begin
                    if (win < 0 && old_pend[(m_ptr + i) % N]) win = (m_ptr + i) % N;
                end
                if (win >= 0) begin
                    m_valid = 1'b1;
                    m_key   = win;
                end
            end
        end
    end

    logic [VW-1:0] dut_vec;
    logic [VW-1:0] mod_vec;
    assign dut_vec = {evt_valid_o, evt_key_o, pending_o, overrun_o};
    always_comb mod_vec = {m_valid, KW'(m_key), m_pend, m_ovr};

    // Lockstep tracker: counts cycles where the DUT departs from the model.
    int            lk_bad = 0;
    int            lk_cyc = 0;
    logic [VW-1:0] lk_dut = '0;
    logic [VW-1:0] lk_mod = '0;
    always @(negedge clk_i) begin
        if (rst_ni && (dut_vec !== mod_vec)) begin
            if (lk_bad == 0) begin
                lk_cyc = tb_cyc;
                lk_dut = dut_vec;
                lk_mod = mod_vec;
            end
            lk_bad++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic pulse_stb(input logic [N-1:0] m);
        key_stb_i = m;
        tick();
        key_stb_i = '0;
    endtask

    task automatic pulse_clr(input logic [N-1:0] m);
        ovr_clr_i = m;
        tick();
        ovr_clr_i = '0;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic wait_accepts(input int target, input int bound);
        for (int i = 0; i < bound && acc_key_q.size() < target; i++) tick();
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound && !evt_valid_o; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        n_checks++;
        if (dut_vec !== '0) $display("FAIL reset_outputs: got %b, required 0", dut_vec);
        else n_pass++;
        n_checks++;
        if (dbg_state_o !== ST_IDLE) $display("FAIL reset_state: got %0d, required %0d", dbg_state_o, ST_IDLE);
        else n_pass++;
        rst_ni = 1'b1;
        tick();
        n_checks++;
        if (dut_vec !== '0) $display("FAIL reset_release_idle: got %b, required 0", dut_vec);
        else n_pass++;
    endtask

    task automatic test_single();
        int base = acc_key_q.size();
        int lk0  = lk_bad;
        evt_ready_i = 1'b1;
        pulse_stb(4'b0100);
        n_checks++;
        if (pending_o !== 4'b0100) $display("FAIL single_pending: got %b, required 0100", pending_o);
        else n_pass++;
        wait_accepts(base + 1, 40);
        pulse_stb(4'b0001);
        wait_accepts(base + 2, 4 * G);
        n_checks++;
        if (acc_key_q.size() < base + 2) $display("FAIL single_timeout: got %0d events, required 2", acc_key_q.size() - base);
        else begin
            n_pass++;
            n_checks++;
            if (acc_key_q[base] !== 2'd2) $display("FAIL single_key: got %0d, required 2", acc_key_q[base]);
            else n_pass++;
            n_checks++;
            if (acc_cyc_q[base+1] - acc_cyc_q[base] !== G + 2)
                $display("FAIL single_gap: got %0d cycles, required %0d", acc_cyc_q[base+1] - acc_cyc_q[base], G + 2);
            else n_pass++;
        end
        repeat (G + 3) tick();
        n_checks++;
        if (lk_bad - lk0 !== 0) $display("FAIL single_lockstep: cyc %0d got %b, required %b", lk_cyc, lk_dut, lk_mod);
        else n_pass++;
    endtask

    task automatic test_multi();
        int base;
        apply_reset();
        base = acc_key_q.size();
        exp_q = '{2'd0, 2'd1, 2'd3};
        evt_ready_i = 1'b1;
        pulse_stb(4'b1011);
        wait_accepts(base + 3, 4 * (G + 2));
        n_checks++;
        if (acc_key_q.size() < base + 3) $display("FAIL multi_timeout: got %0d events, required 3", acc_key_q.size() - base);
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (acc_key_q[base+i] !== exp_q[i]) $display("FAIL multi_order[%0d]: got %0d, required %0d", i, acc_key_q[base+i], exp_q[i]);
                else n_pass++;
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (acc_cyc_q[base+i] - acc_cyc_q[base+i-1] !== G + 2)
                    $display("FAIL multi_spacing[%0d]: got %0d, required %0d", i, acc_cyc_q[base+i] - acc_cyc_q[base+i-1], G + 2);
                else n_pass++;
            end
        end
        repeat (G + 3) tick();
        n_checks++;
        if ({evt_valid_o, pending_o} !== 5'b0) $display("FAIL multi_drained: got valid=%b pending=%b, required 0/0000", evt_valid_o, pending_o);
        else n_pass++;
    endtask

    task automatic test_hold();
        int bad = 0;
        int base;
        evt_ready_i = 1'b0;
        pulse_stb(4'b0010);
        wait_valid(10);
        for (int i = 0; i < 50; i++) begin
            if (!(evt_valid_o === 1'b1 && evt_key_o === 2'd1)) bad++;
            if (i == 10) pulse_stb(4'b0010);
            else tick();
        end
        n_checks++;
        if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles, required 0", bad);
        else n_pass++;
        n_checks++;
        if (overrun_o !== 4'b0010) $display("FAIL hold_overrun_set: got %b, required 0010", overrun_o);
        else n_pass++;
        pulse_clr(4'b0010);
        n_checks++;
        if (overrun_o !== 4'b0000) $display("FAIL hold_overrun_clr: got %b, required 0000", overrun_o);
        else n_pass++;
        key_stb_i = 4'b0010;
        ovr_clr_i = 4'b0010;
        tick();
        key_stb_i = '0;
        ovr_clr_i = '0;
        n_checks++;
        if (overrun_o !== 4'b0010) $display("FAIL hold_set_wins: got %b, required 0010", overrun_o);
        else n_pass++;
        pulse_clr(4'b0010);
        base = acc_key_q.size();
        evt_ready_i = 1'b1;
        repeat (G + 4) tick();
        n_checks++;
        if (acc_key_q.size() !== base + 1) $display("FAIL hold_one_event: got %0d events, required 1", acc_key_q.size() - base);
        else n_pass++;
        n_checks++;
        if ({overrun_o, pending_o} !== 8'b0) $display("FAIL hold_after: got ovr=%b pend=%b, required 0000/0000", overrun_o, pending_o);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        int base;
        evt_ready_i = 1'b0;
        pulse_stb(4'b0001);
        wait_valid(10);
        base = acc_key_q.size();
        evt_ready_i = 1'b1;
        key_stb_i   = 4'b0001;
        tick();
        key_stb_i   = '0;
        n_checks++;
        if ({overrun_o[0], pending_o[0], evt_valid_o} !== 3'b010)
            $display("FAIL same_cycle_flags: got ovr0=%b pend0=%b valid=%b, required 0/1/0", overrun_o[0], pending_o[0], evt_valid_o);
        else n_pass++;
        wait_accepts(base + 2, 3 * G);
        n_checks++;
        if (acc_key_q.size() < base + 2) $display("FAIL same_cycle_timeout: got %0d events, required 2", acc_key_q.size() - base);
        else begin
            n_pass++;
            n_checks++;
            if ({acc_key_q[base], acc_key_q[base+1]} !== 4'b0000)
                $display("FAIL same_cycle_keys: got %0d,%0d, required 0,0", acc_key_q[base], acc_key_q[base+1]);
            else n_pass++;
            n_checks++;
            if (acc_cyc_q[base+1] - acc_cyc_q[base] !== G + 2)
                $display("FAIL same_cycle_gap: got %0d, required %0d", acc_cyc_q[base+1] - acc_cyc_q[base], G + 2);
            else n_pass++;
        end
        repeat (G + 3) tick();
    endtask

    task automatic test_wrap();
        int base = acc_key_q.size();
        exp_q = '{2'd3, 2'd0, 2'd3};
        evt_ready_i = 1'b1;
        pulse_stb(4'b1000);
        wait_accepts(base + 1, 10);
        pulse_stb(4'b1001);
        wait_accepts(base + 3, 3 * (G + 2));
        n_checks++;
        if (acc_key_q.size() < base + 3) $display("FAIL wrap_timeout: got %0d events, required 3", acc_key_q.size() - base);
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (acc_key_q[base+i] !== exp_q[i]) $display("FAIL wrap_order[%0d]: got %0d, required %0d", i, acc_key_q[base+i], exp_q[i]);
                else n_pass++;
            end
        end
        repeat (G + 3) tick();
    endtask

    task automatic test_random();
        int lk0  = lk_bad;
        int base = acc_key_q.size();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                key_stb_i[k] = ($urandom_range(0, 31) == 0);
                ovr_clr_i[k] = ($urandom_range(0, 15) == 0);
            end
            evt_ready_i = ($urandom_range(0, 9) < 7);
            tick();
        end
        key_stb_i   = '0;
        ovr_clr_i   = '0;
        evt_ready_i = 1'b1;
        for (int i = 0; i < 8 * (G + 2) && (pending_o != '0 || evt_valid_o); i++) tick();
        n_checks++;
        if ({evt_valid_o, pending_o} !== 5'b0) $display("FAIL random_drain: got valid=%b pend=%b, required 0/0000", evt_valid_o, pending_o);
        else n_pass++;
        n_checks++;
        if (acc_key_q.size() - base < 20) $display("FAIL random_activity: got %0d events, required at least 20", acc_key_q.size() - base);
        else n_pass++;
        n_checks++;
        if (lk_bad - lk0 !== 0) $display("FAIL random_lockstep: %0d bad cycles, first cyc %0d got %b, required %b", lk_bad - lk0, lk_cyc, lk_dut, lk_mod);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        int seen = 0;
        apply_reset();
        evt_ready_i = 1'b0;
        pulse_stb(4'b0111);
        wait_valid(10);
        n_checks++;
        if ({evt_valid_o, pending_o} !== 5'b1_0111) $display("FAIL rmid_offer: got valid=%b pend=%b, required 1/0111", evt_valid_o, pending_o);
        else n_pass++;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== '0) $display("FAIL rmid_async_clear: got %b, required 0", dut_vec);
        else n_pass++;
        n_checks++;
        if (dbg_state_o !== ST_IDLE) $display("FAIL rmid_state: got %0d, required %0d", dbg_state_o, ST_IDLE);
        else n_pass++;
        @(negedge clk_i);
        tick();
        rst_ni = 1'b1;
        evt_ready_i = 1'b1;
        base = acc_key_q.size();
        repeat (40) begin
            tick();
            if (evt_valid_o) seen++;
        end
        n_checks++;
        if (seen !== 0 || acc_key_q.size() !== base)
            $display("FAIL rmid_no_event: got %0d valid cycles and %0d events, required 0/0", seen, acc_key_q.size() - base);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_multi();
        test_hold();
        test_same_cycle();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
